// File: rtl/cache_pkg.sv
// Shared cache types.
//   lsu_ops          : memory operation encoding used on the DRAM port (LW / SW)
//   mem_ctrl_state_t : DRAM request master FSM states
package cache_pkg;

    typedef enum logic {
        LW = 1'b0,
        SW = 1'b1
    } lsu_ops;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        WB   = 3'd1,
        RD   = 3'd2,
        CAP  = 3'd3,
        RESP = 3'd4,
        ERR  = 3'd5
    } mem_ctrl_state_t;

endpackage

// File: rtl/dram_req_master.sv
// DRAM request master for cache misses.
// Accepts one miss request at a time. If the victim is dirty, it first writes
// the victim line back (SW), then it fetches the fill word (LW). The word is
// captured one cycle after the DRAM accepts the read and is returned with a
// one-cycle resp_valid pulse. If the DRAM withholds mem_ready for TIMEOUT
// consecutive cycles, the request is dropped and err_valid pulses instead.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   req_valid/req_ready      miss request handshake (req_ready == idle)
//   req_wb, req_addr         dirty-victim flag, fill address
//   wb_addr, wb_data         victim address and victim line
//   resp_valid, resp_data    fill data, one-cycle pulse; data held afterwards
//   err_valid                timeout abort, one-cycle pulse
//   busy                     FSM not idle
//   mem_req, mem_op,
//   mem_address, mem_wdata   DRAM command, zero whenever no request is issued
//   mem_ready                DRAM accepted the command this cycle
//   dram_data_out            DRAM read data, valid the cycle after an accepted LW
module dram_req_master
    import cache_pkg::*;
#(
    parameter int TAG     = 20,
    parameter int DATA    = 32,
    parameter int TIMEOUT = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_wb,
    input  logic [31:0]           req_addr,
    input  logic [31:0]           wb_addr,
    input  logic [TAG+DATA:0]     wb_data,
    output logic                  resp_valid,
    output logic [DATA-1:0]       resp_data,
    output logic                  err_valid,
    output logic                  busy,
    output logic                  mem_req,
    output lsu_ops                mem_op,
    output logic [31:0]           mem_address,
    output logic [TAG+DATA:0]     mem_wdata,
    input  logic                  mem_ready,
    input  logic [DATA-1:0]       dram_data_out
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    mem_ctrl_state_t     state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [31:0]         req_addr_q, req_addr_d;
    logic [31:0]         wb_addr_q, wb_addr_d;
    logic [TAG+DATA:0]   wb_data_q, wb_data_d;
    logic                req_wb_q, req_wb_d;
    logic [DATA-1:0]     resp_data_q, resp_data_d;

    logic accept;
    logic timeout_hit;

    assign accept = req_valid && (state_q == IDLE);
    // This stalled cycle would bring the counter up to TIMEOUT.
    assign timeout_hit = !mem_ready && (cnt_q == CNT_LAST);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values; reset is synchronous, hence inside the
    // clocked branch rather than in the sensitivity list.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    // NOTE: every combinational output gets a default first so no path
    // through the case leaves it unassigned (which would infer a latch).
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (accept) state_d = req_wb ? WB : RD;
            WB: begin
                if (mem_ready)        state_d = RD;
                else if (timeout_hit) state_d = ERR;
            end
            RD: begin
                if (mem_ready)        state_d = CAP;
                else if (timeout_hit) state_d = ERR;
            end
            CAP:     state_d = RESP;
            RESP:    state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic
    // ------------------------------------------------------------------
    always_comb begin
        req_ready   = (state_q == IDLE);
        busy        = (state_q != IDLE);
        resp_valid  = (state_q == RESP);
        err_valid   = (state_q == ERR);
        resp_data   = resp_data_q;
        mem_req     = 1'b0;
        mem_op      = LW;
        mem_address = '0;
        mem_wdata   = '0;
        unique case (state_q)
            WB: begin
                mem_req     = 1'b1;
                mem_op      = SW;
                mem_address = wb_addr_q;
                mem_wdata   = wb_data_q;
            end
            RD: begin
                mem_req     = 1'b1;
                mem_op      = LW;
                mem_address = req_addr_q;
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Timeout counter: cleared on entry to WB/RD and whenever the DRAM
    // accepts; counts stalled WB/RD cycles and saturates at TIMEOUT.
    // ------------------------------------------------------------------
    always_comb begin
        cnt_d = cnt_q;
        if ((state_d == WB || state_d == RD) && (state_d != state_q)) begin
            cnt_d = '0;
        end else if (state_q == WB || state_q == RD) begin
            if (mem_ready) begin
                cnt_d = '0;
            end else if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Request latch and fill-data capture
    // ------------------------------------------------------------------
    always_comb begin
        req_addr_d  = req_addr_q;
        wb_addr_d   = wb_addr_q;
        wb_data_d   = wb_data_q;
        req_wb_d    = req_wb_q;
        resp_data_d = resp_data_q;
        if (accept) begin
            req_addr_d = req_addr;
            wb_addr_d  = wb_addr;
            wb_data_d  = wb_data;
            req_wb_d   = req_wb;
        end
        // Read data arrives the cycle after the LW was accepted, i.e. in CAP.
        if (state_q == CAP) begin
            resp_data_d = dram_data_out;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q       <= '0;
            req_addr_q  <= '0;
            wb_addr_q   <= '0;
            wb_data_q   <= '0;
            req_wb_q    <= 1'b0;
            resp_data_q <= '0;
        end else begin
            cnt_q       <= cnt_d;
            req_addr_q  <= req_addr_d;
            wb_addr_q   <= wb_addr_d;
            wb_data_q   <= wb_data_d;
            req_wb_q    <= req_wb_d;
            resp_data_q <= resp_data_d;
        end
    end

endmodule

// File: tb/tb_dram_req_master.sv
// Self-checking bench for dram_req_master.
// A small DRAM model answers the master; each accepted request pushes its
// expected outcome (response or error, data, due cycle) onto a scoreboard
// that a negedge monitor pops when resp_valid / err_valid appear.
module tb_dram_req_master;
    import cache_pkg::*;

    localparam int TAG     = 20;
    localparam int DATA    = 32;
    localparam int TIMEOUT = 16;
    localparam int WBW     = TAG + DATA + 1;

    logic            clk = 1'b0;
    logic            rst;
    logic            req_valid;
    logic            req_ready;
    logic            req_wb;
    logic [31:0]     req_addr;
    logic [31:0]     wb_addr;
    logic [WBW-1:0]  wb_data;
    logic            resp_valid;
    logic [DATA-1:0] resp_data;
    logic            err_valid;
    logic            busy;
    logic            mem_req;
    lsu_ops          mem_op;
    logic [31:0]     mem_address;
    logic [WBW-1:0]  mem_wdata;
    logic            mem_ready;
    logic [DATA-1:0] dram_data_out;

    dram_req_master #(.TAG(TAG), .DATA(DATA), .TIMEOUT(TIMEOUT)) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_wb        (req_wb),
        .req_addr      (req_addr),
        .wb_addr       (wb_addr),
        .wb_data       (wb_data),
        .resp_valid    (resp_valid),
        .resp_data     (resp_data),
        .err_valid     (err_valid),
        .busy          (busy),
        .mem_req       (mem_req),
        .mem_op        (mem_op),
        .mem_address   (mem_address),
        .mem_wdata     (mem_wdata),
        .mem_ready     (mem_ready),
        .dram_data_out (dram_data_out)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    // ---------------- check bookkeeping ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    // ---------------- DRAM model ----------------
    logic [DATA-1:0] dram [256];
    int stall_cfg = 0;     // LW stall cycles before accepting
    bit force_low = 1'b0;  // hold mem_ready low (timeout tests)
    int lw_wait   = 0;

    assign mem_ready = !force_low && !(mem_req && mem_op == LW && lw_wait < stall_cfg);

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 256; i++) dram[i] <= 32'hA500_0000 + i;
            dram[8'h10] <= 32'hDEAD_BEEF;
            lw_wait <= 0;
        end else begin
            if (mem_req && mem_ready) begin
                if (mem_op == SW) dram[mem_address[7:0]] <= mem_wdata[DATA-1:0];
                else              dram_data_out <= dram[mem_address[7:0]];
                lw_wait <= 0;
            end else if (mem_req && mem_op == LW) begin
                lw_wait <= lw_wait + 1;
            end
        end
    end

    // ---------------- scoreboard + monitor ----------------
    typedef struct {
        bit              is_err;
        logic [DATA-1:0] data;
        int              due;
    } exp_t;

    exp_t sb[$];

    logic [31:0]    exp_wb_addr = '0;
    logic [WBW-1:0] exp_wb_data = '0;
    logic [31:0]    exp_rd_addr = '0;

    int sw_cyc = 0, lw_cyc = 0, proto_errs = 0;

    always @(negedge clk) begin
        if (!rst) begin
            if (mem_req) begin
                if (mem_op == SW) begin
                    sw_cyc++;
                    if (mem_address !== exp_wb_addr || mem_wdata !== exp_wb_data) proto_errs++;
                end else begin
                    lw_cyc++;
                    if (mem_address !== exp_rd_addr || mem_wdata !== '0) proto_errs++;
                end
            end else if (mem_op !== LW || mem_address !== '0 || mem_wdata !== '0) begin
                proto_errs++;
            end
            if (resp_valid || err_valid) begin
                check("resp_err_exclusive", 64'(resp_valid & err_valid), 0);
                if (sb.size() == 0) begin
                    check("unexpected_output", 64'({resp_valid, err_valid}), 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("out_kind_err", 64'(err_valid), 64'(e.is_err));
                    if (!e.is_err) check("resp_data", 64'(resp_data), 64'(e.data));
                    check("out_cycle", 64'(cyc + 1), 64'(e.due));
                end
            end
        end
    end

    // ---------------- vector table ----------------
    typedef struct {
        bit              wb;
        logic [31:0]     addr;
        logic [31:0]     wb_addr;
        logic [WBW-1:0]  wb_data;
        int              stall;
        bit              timeout;
        logic [DATA-1:0] data;
        int              lat;
        int              n_sw;
        int              n_lw;
    } vec_t;

    vec_t vecs[7];

    // Present a request, wait for req_ready, record expectation, drop valid.
    task automatic send(input vec_t v);
        int n;
        @(negedge clk);
        req_wb    = v.wb;
        req_addr  = v.addr;
        wb_addr   = v.wb_addr;
        wb_data   = v.wb_data;
        stall_cfg = v.stall;
        force_low = v.timeout;
        req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("req_ready_at_issue", 64'(req_ready), 1);
        exp_wb_addr = v.wb_addr;
        exp_wb_data = v.wb_data;
        exp_rd_addr = v.addr;
        sb.push_back('{is_err: v.timeout, data: v.data, due: cyc + 1 + v.lat});
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("scoreboard_drained", 64'(sb.size()), 0);
        force_low = 1'b0;
        stall_cfg = 0;
    endtask

    task automatic run_vec(input int idx);
        int sw0, lw0, pe0;
        sw0 = sw_cyc; lw0 = lw_cyc; pe0 = proto_errs;
        send(vecs[idx]);
        drain(60);
        @(negedge clk);
        check($sformatf("v%0d_ready_after", idx), 64'(req_ready), 1);
        check($sformatf("v%0d_busy_after", idx), 64'(busy), 0);
        repeat (3) @(negedge clk);
        check($sformatf("v%0d_sw_cycles", idx), 64'(sw_cyc - sw0), 64'(vecs[idx].n_sw));
        check($sformatf("v%0d_lw_cycles", idx), 64'(lw_cyc - lw0), 64'(vecs[idx].n_lw));
        check($sformatf("v%0d_mem_port", idx), 64'(proto_errs - pe0), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n, acc_a, acc_b;
        // wb, addr, wb_addr, wb_data, stall, timeout, data, lat, n_sw, n_lw
        vecs[0] = '{1'b0, 32'h010, 32'h000, '0, 0, 1'b0, 32'hDEAD_BEEF, 3, 0, 1};
        vecs[1] = '{1'b1, 32'h020, 32'h020, {1'b1, 20'hABCDE, 32'h1234_5678}, 0, 1'b0, 32'h1234_5678, 4, 1, 1};
        vecs[2] = '{1'b0, 32'h010, 32'h000, '0, 5, 1'b0, 32'hDEAD_BEEF, 8, 0, 6};
        vecs[3] = '{1'b0, 32'h030, 32'h000, '0, 0, 1'b1, 32'h0, 17, 0, 16};
        vecs[4] = '{1'b1, 32'h034, 32'h040, {1'b0, 20'h11111, 32'h5555_AAAA}, 0, 1'b1, 32'h0, 17, 16, 0};
        vecs[5] = '{1'b0, 32'h030, 32'h000, '0, 0, 1'b0, 32'hA500_0030, 3, 0, 1};
        vecs[6] = '{1'b1, 32'h044, 32'h050, {1'b1, 20'h00F0F, 32'hCAFE_F00D}, 2, 1'b0, 32'hA500_0044, 6, 1, 3};

        rst = 1'b1; req_valid = 1'b0; req_wb = 1'b0;
        req_addr = '0; wb_addr = '0; wb_data = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_req_ready",   64'(req_ready), 1);
        check("rst_busy",        64'(busy), 0);
        check("rst_resp_valid",  64'(resp_valid), 0);
        check("rst_err_valid",   64'(err_valid), 0);
        check("rst_mem_req",     64'(mem_req), 0);
        check("rst_mem_op",      64'(mem_op), 64'(LW));
        check("rst_mem_address", 64'(mem_address), 0);
        check("rst_mem_wdata",   64'(mem_wdata), 0);
        check("rst_resp_data",   64'(resp_data), 0);

        for (int i = 0; i < 7; i++) run_vec(i);

        // resp_data holds the last fill while idle.
        check("resp_data_hold", 64'(resp_data), 64'(32'hA500_0044));

        // Reset while in WB: abort with no responses, then a normal fill.
        @(negedge clk);
        req_wb = 1'b1; wb_addr = 32'h080; wb_data = {1'b1, 20'h0ABCD, 32'h0BAD_0BAD};
        req_addr = 32'h084; req_valid = 1'b1;
        exp_wb_addr = 32'h080; exp_wb_data = {1'b1, 20'h0ABCD, 32'h0BAD_0BAD}; exp_rd_addr = 32'h084;
        @(negedge clk);
        req_valid = 1'b0;
        check("midwb_in_wb_req", 64'(mem_req), 1);
        check("midwb_in_wb_op",  64'(mem_op), 64'(SW));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midwb_mem_req_off", 64'(mem_req), 0);
        check("midwb_idle",        64'(req_ready), 1);
        check("midwb_busy",        64'(busy), 0);
        check("midwb_resp_data",   64'(resp_data), 0);
        repeat (6) @(negedge clk);
        run_vec(0);

        // Back-to-back with req_valid held high across both requests.
        @(negedge clk);
        req_wb = 1'b0; req_addr = 32'h010; req_valid = 1'b1;
        check("b2b_a_ready", 64'(req_ready), 1);
        exp_rd_addr = 32'h010;
        acc_a = cyc + 1;
        sb.push_back('{is_err: 1'b0, data: 32'hDEAD_BEEF, due: acc_a + 3});
        @(negedge clk);
        req_addr = 32'h030;
        check("b2b_busy_ignored", 64'(req_ready), 0);
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        acc_b = cyc + 1;
        check("b2b_accept_gap", 64'(acc_b - acc_a), 4);
        check("b2b_a_data_held", 64'(resp_data), 64'(32'hDEAD_BEEF));
        exp_rd_addr = 32'h030;
        sb.push_back('{is_err: 1'b0, data: 32'hA500_0030, due: acc_b + 3});
        @(negedge clk);
        req_valid = 1'b0;
        drain(30);
        repeat (4) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/dram_req_master.md
DRAM_REQ_MASTER -- requirements
Module: dram_req_master

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset: clk sampled on rising edge; rst synchronous, active-high.
REQ-002 Parameter TAG, default 20, SHALL set the tag width carried in writeback data.
REQ-003 Parameter DATA, default 32, SHALL set the DRAM data word width.
REQ-004 Parameter TIMEOUT, default 16, SHALL set the number of consecutive cycles without mem_ready before abort.
REQ-005 Ports SHALL be, in order:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_valid  in  1  cache miss request
- req_ready  out  1  block idle and accepting
- req_wb  in  1  dirty victim; writeback precedes fill
- req_addr  in  32  fill address
- wb_addr  in  32  victim address
- wb_data  in  TAG+DATA+1  victim line
- resp_valid  out  1  fill data valid, one-cycle pulse
- resp_data  out  DATA  fill data
- err_valid  out  1  timeout abort, one-cycle pulse
- busy  out  1  state not IDLE
- mem_req  out  1  DRAM request/enable
- mem_op  out  lsu_ops  LW or SW
- mem_address  out  32  DRAM address
- mem_wdata  out  TAG+DATA+1  DRAM write data
- mem_ready  in  1  DRAM accepted this cycle
- dram_data_out  in  DATA  DRAM read data, valid the cycle after an accepted LW

Function
REQ-006 FSM states SHALL be IDLE, WB, RD, CAP, RESP, ERR.
REQ-007 req_ready SHALL equal (state==IDLE); a request is accepted on an edge with req_valid && req_ready, latching req_addr, wb_addr, wb_data and req_wb.
REQ-008 On acceptance, the FSM SHALL go to WB if req_wb=1, else RD.
REQ-009 In WB: mem_req=1, mem_op=SW, mem_address=latched wb_addr, mem_wdata=latched wb_data; on mem_ready the FSM SHALL go to RD.
REQ-010 In RD: mem_req=1, mem_op=LW, mem_address=latched req_addr; on mem_ready the FSM SHALL go to CAP.
REQ-011 In CAP: mem_req=0; resp_data SHALL register dram_data_out; the FSM SHALL go to RESP.
REQ-012 In RESP: resp_valid=1 for exactly one cycle; the FSM SHALL go to IDLE; resp_data SHALL hold until the next capture.
REQ-013 Latency with an always-ready DRAM SHALL be 3 cycles from the acceptance edge to resp_valid without writeback, and 4 cycles with writeback.
REQ-014 In IDLE, CAP, RESP and ERR: mem_req=0, mem_op=LW, mem_address=0, mem_wdata=0.
REQ-015 The timeout counter SHALL clear on entry to WB and RD and on mem_ready; it SHALL increment each WB/RD cycle with mem_ready=0.
REQ-016 When the counter reaches TIMEOUT, the FSM SHALL go to ERR, discarding the request; no resp_valid SHALL follow.
REQ-017 ERR SHALL assert err_valid for one cycle, then the FSM SHALL go to IDLE.
REQ-018 The counter width SHALL be $clog2(TIMEOUT+1) and the counter SHALL NOT wrap.
REQ-019 req_valid outside IDLE SHALL be ignored, with no queuing; the requester holds the request until req_ready.
REQ-020 resp_valid and err_valid SHALL never be asserted in the same cycle.
REQ-021 busy SHALL be (state != IDLE).

Reset
REQ-022 On a rst edge the FSM SHALL enter IDLE, clear the counter and clear all latched request registers and resp_data.
REQ-023 After reset: req_ready=1, busy=0, resp_valid=0, err_valid=0, mem_req=0, mem_op=LW, mem_address=0, mem_wdata=0, resp_data=0.
REQ-024 Reset mid-transaction SHALL abort it, deassert mem_req in the next cycle, and produce no resp_valid or err_valid.

Structure
REQ-025 The FSM state enum (mem_ctrl_state_t) SHALL be added to cache_pkg, reusing its existing lsu_ops (LW, SW).
REQ-026 The block SHALL be a single module with no sub-modules.

Verification
REQ-027 Fill, no writeback, paired with the team DRAM model holding 0xDEADBEEF at word 0x010: req_addr=0x010, req_wb=0 -> one mem_req LW cycle, resp_valid exactly 3 cycles after acceptance, resp_data=0xDEADBEEF.
REQ-028 Writeback then fill: req_wb=1, wb_addr=0x020, wb_data low DATA bits=0x12345678, req_addr=0x020 -> SW cycle, then LW cycle, resp_valid after 4 cycles, resp_data=0x12345678.
REQ-029 Timeout: mem_ready forced 0 with TIMEOUT=16 -> err_valid pulse 17 cycles after entering RD, no resp_valid, req_ready=1 the following cycle.
REQ-030 Stall: mem_ready held low 5 cycles in RD -> mem_req and mem_address stay stable, and resp arrives 5 cycles later than REQ-027.
REQ-031 Reset mid-WB (rst high one cycle while in WB) -> mem_req=0 the next cycle, IDLE, no responses; a subsequent fill then completes normally.
REQ-032 Back-to-back: req_valid held high across two requests -> second accepted only on the cycle after RESP; req_valid during busy is ignored.
